// File: rtl/div_seq_64_pkg.sv
// Shared types and constants for the 64-bit sequential divider (div_seq_64).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  typedef logic [1:0] div_op_t;

  localparam div_op_t DIV_OP_DIV  = 2'b00;
  localparam div_op_t DIV_OP_DIVU = 2'b01;
  localparam div_op_t DIV_OP_REM  = 2'b10;
  localparam div_op_t DIV_OP_REMU = 2'b11;

  localparam int unsigned DIV_ITERS   = 64;
  localparam int unsigned DIV_CNT_W   = $clog2(DIV_ITERS);
  localparam logic [63:0] DIV_INT_MIN = 64'h8000_0000_0000_0000;

  function automatic logic [63:0] div_neg(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic div_is_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic div_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_seq_64_if.sv
// Request/response handshake bundle of div_seq_64; master = issuing pipeline, slave = divider.
interface div_seq_64_if;
  import div_pkg::*;

  logic        req_valid;
  logic        req_ready;
  div_op_t     op;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic        div_by_zero;

  modport master (
    output req_valid, op, dividend, divisor, resp_ready,
    input  req_ready, resp_valid, result, div_by_zero
  );

  modport slave (
    input  req_valid, op, dividend, divisor, resp_ready,
    output req_ready, resp_valid, result, div_by_zero
  );

endinterface

// File: rtl/div_seq_64_step.sv
// One restoring shift-subtract step of the divider: shifts {rem, quo} left and restores.
module div_step_64 (
  input  logic [64:0] rem_i,
  input  logic [63:0] quo_i,
  input  logic [63:0] div_i,
  output logic [64:0] rem_o,
  output logic [63:0] quo_o
);

  logic [65:0] rem_sh;
  logic [65:0] trial;

  // One guard bit above the 65-bit remainder keeps the sign of the trial exact.
  assign rem_sh = {rem_i, quo_i[63]};
  assign trial  = rem_sh - {2'b00, div_i};

  always_comb begin
    rem_o = rem_sh[64:0];
    quo_o = {quo_i[62:0], 1'b0};
    if (!trial[65]) begin
      rem_o    = trial[64:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq_64.sv
// Sequential 64-bit RV64M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: zero divisor and signed overflow complete in one cycle.
module div_seq_64
  import div_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  div_seq_64_if.slave bus
);

  div_state_e           state_q, state_d;
  div_op_t              op_q, op_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [64:0]          rem_q, rem_d;
  logic [63:0]          quo_q, quo_d;
  logic [63:0]          mag_b_q, mag_b_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]          result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic                 req_signed;
  logic [63:0]          req_mag_a;
  logic [63:0]          req_mag_b;
  logic [64:0]          step_rem;
  logic [63:0]          step_quo;
  logic [63:0]          fix_quo;
  logic [63:0]          fix_rem;

  assign req_signed = div_is_signed(bus.op);
  assign req_mag_a  = (req_signed && bus.dividend[63]) ? div_neg(bus.dividend) : bus.dividend;
  assign req_mag_b  = (req_signed && bus.divisor[63])  ? div_neg(bus.divisor)  : bus.divisor;

  div_step_64 u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (mag_b_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // A zero divisor leaves the all-ones quotient untouched regardless of signs.
  assign fix_quo = (div_is_signed(op_q) && (sign_a_q != sign_b_q) && (mag_b_q != '0))
                   ? div_neg(quo_q) : quo_q;
  assign fix_rem = (div_is_signed(op_q) && sign_a_q) ? div_neg(rem_q[63:0]) : rem_q[63:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      mag_b_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mag_b_q  <= mag_b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mag_b_d  = mag_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.op;
          sign_a_d = req_signed & bus.dividend[63];
          sign_b_d = req_signed & bus.divisor[63];
          mag_b_d  = req_mag_b;
          rem_d    = '0;
          quo_d    = req_mag_a;
          cnt_d    = DIV_CNT_W'(DIV_ITERS - 1);
          state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (bus.divisor == '0) begin
            result_d = div_is_rem(bus.op) ? bus.dividend : '1;
            dbz_d    = 1'b1;
            state_d  = DONE;
          end else if (req_signed && (bus.dividend == DIV_INT_MIN) && (bus.divisor == '1)) begin
            result_d = div_is_rem(bus.op) ? '0 : DIV_INT_MIN;
            dbz_d    = 1'b0;
            state_d  = DONE;
          end
`endif
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIX: begin
        result_d = div_is_rem(op_q) ? fix_rem : fix_quo;
        dbz_d    = (mag_b_q == '0);
        state_d  = DONE;
      end

      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_64.sv
// Scoreboarded random + directed bench for div_seq_64 against an arithmetic reference model.
module tb_div_seq_64;
  import div_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  div_seq_64_if bus ();

  div_seq_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  exp_t        sbq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference: RISC-V M-extension division semantics from plain arithmetic.
  function automatic exp_t model(input div_op_t op, input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic               is_s;
    logic               is_r;
    sa    = a;
    sb    = b;
    is_s  = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    is_r  = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    e.dbz = (b == 64'd0);
    if (b == 64'd0)                                  e.res = is_r ? a : ALL1;
    else if (is_s && a == DIV_INT_MIN && b == ALL1)  e.res = is_r ? 64'd0 : DIV_INT_MIN;
    else if (is_s)                                   e.res = is_r ? 64'(sa % sb) : 64'(sa / sb);
    else                                             e.res = is_r ? a % b : a / b;
    return e;
  endfunction

  function automatic int unsigned exp_lat(input div_op_t op, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic is_s;
    is_s = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 64'd0 || (is_s && a == DIV_INT_MIN && b == ALL1)) return 1;
`endif
    return 66;
  endfunction

  // Monitor: pops an expectation when a response appears and checks it stays stable.
  logic [63:0] cap_res;
  logic        cap_dbz;
  bit          seen = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.resp_valid) begin
      if (!seen) begin
        seen    = 1'b1;
        cap_res = bus.result;
        cap_dbz = bus.div_by_zero;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got result %h expected no response", bus.result);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", bus.result, mon_e.res);
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
        end
      end else begin
        chk("result_stable", bus.result, cap_res);
        chk("dbz_stable", 64'(bus.div_by_zero), 64'(cap_dbz));
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input div_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input exp_t e, input int unsigned hold);
    int unsigned n;
    int unsigned lat;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.op        = op;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.req_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.op        = div_op_t'($urandom_range(0, 3));
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
    lat = 1;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat(op, a, b)));
    repeat (hold) begin
      chk("req_ready_in_done", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid_after_hs", 64'(bus.resp_valid), 64'd0);
    chk("req_ready_after_hs", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic issue_m(input div_op_t op, input logic [63:0] a, input logic [63:0] b);
    issue(op, a, b, model(op, a, b), $urandom_range(0, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nv;
    logic [63:0] ra;
    logic [63:0] rb;
    div_op_t     rop;

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op         = '0;
    bus.dividend   = '0;
    bus.divisor    = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Directed cases with hand-derived expectations.
    issue(DIV_OP_DIVU, 64'd100, 64'd7, '{res: 64'd14, dbz: 1'b0}, 10);
    issue(DIV_OP_REMU, 64'd100, 64'd7, '{res: 64'd2, dbz: 1'b0}, 0);
    issue(DIV_OP_DIV, -64'sd100, 64'd7, '{res: 64'hFFFF_FFFF_FFFF_FFF2, dbz: 1'b0}, 1);
    issue(DIV_OP_REM, -64'sd100, 64'd7, '{res: 64'hFFFF_FFFF_FFFF_FFFE, dbz: 1'b0}, 2);
    issue(DIV_OP_REM, 64'd100, -64'sd7, '{res: 64'd2, dbz: 1'b0}, 0);
    issue(DIV_OP_DIV, 64'd5, 64'd0, '{res: ALL1, dbz: 1'b1}, 3);
    issue(DIV_OP_REMU, 64'd5, 64'd0, '{res: 64'd5, dbz: 1'b1}, 0);
    issue(DIV_OP_DIV, DIV_INT_MIN, ALL1, '{res: DIV_INT_MIN, dbz: 1'b0}, 1);
    issue(DIV_OP_REM, DIV_INT_MIN, ALL1, '{res: 64'd0, dbz: 1'b0}, 0);

    // Reset in the middle of CALC discards the request.
    @(negedge clk);
    bus.op        = DIV_OP_DIVU;
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom} | 64'd1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_dbz", 64'(bus.div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    nv = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) nv++;
    end
    chk("no_resp_after_reset", 64'(nv), 64'd0);
    issue(DIV_OP_DIVU, 64'd9, 64'd3, '{res: 64'd3, dbz: 1'b0}, 0);

    // Randomised operands biased toward the interesting corners.
    for (int i = 0; i < 30; i++) begin
      rop = div_op_t'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 50)); end
        1: rb = 64'd0;
        2: begin ra = DIV_INT_MIN; rb = ALL1; end
        3: rb = 64'($urandom_range(1, 20));
        4: begin rb = -64'($urandom_range(1, 20)); end
        default: ;
      endcase
      issue_m(rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
